// File: rtl/wb_stage.sv
// wb_stage: writeback stage with load extract/extend, write qualification and load timeout
module wb_stage #(
  parameter int LD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_pc,
  input  logic [1:0]  in_addr_lo,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        retire,
  output logic        load_timeout
);
  localparam int CW = $clog2(LD_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_LD, WRITE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d, alu_q, alu_d, pc_q, pc_d;
  logic [1:0] wb_sel_q, wb_sel_d, addr_lo_q, addr_lo_d;
  logic rf_we_q, rf_we_d, retire_q, retire_d, load_timeout_q, load_timeout_d;
  logic [4:0] rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic accept, waiting, rsp, expire, go, ok, src_load, op_ok, f3_ok;
  logic [31:0] src_instr, src_alu, src_pc, ld_data, sel_data;
  logic [1:0] src_sel, src_addr;
  logic [6:0] op;
  logic [2:0] f3;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  assign in_ready = !rst && state_q != WAIT_LD;
  always_comb begin
    accept = in_valid && in_ready;
    waiting = state_q == WAIT_LD;
    rsp = waiting && mem_rsp_valid;
    expire = waiting && !mem_rsp_valid && cnt_q == CW'(LD_TIMEOUT - 1);
    state_d = waiting ? ((rsp || expire) ? WRITE : WAIT_LD)
            : accept ? ((in_instr[6:0] == 7'b0000011) ? WAIT_LD : WRITE) : IDLE;
    cnt_d = (waiting && !rsp && !expire) ? cnt_q + 1'b1 : '0;
    instr_d = accept ? in_instr : instr_q;
    alu_d = accept ? in_alu : alu_q;
    pc_d = accept ? in_pc : pc_q;
    wb_sel_d = accept ? in_wb_sel : wb_sel_q;
    addr_lo_d = accept ? in_addr_lo : addr_lo_q;
    // A completing load writes from its captured fields, anything else from the live beat
    src_instr = waiting ? instr_q : in_instr;
    src_alu = waiting ? alu_q : in_alu;
    src_pc = waiting ? pc_q : in_pc;
    src_sel = waiting ? wb_sel_q : in_wb_sel;
    src_addr = waiting ? addr_lo_q : in_addr_lo;
    op = src_instr[6:0];
    f3 = src_instr[14:12];
    src_load = op == 7'b0000011;
    op_ok = op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111 || op == 7'b1100111
         || op == 7'b0000011 || op == 7'b0010011 || op == 7'b0110011;
    f3_ok = f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101;
    byte_v = 8'(mem_rsp_data >> {src_addr, 3'b000});
    half_v = src_addr[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    ld_data = !rsp ? 32'h0
            : f3 == 3'b000 ? {{24{byte_v[7]}}, byte_v}
            : f3 == 3'b001 ? {{16{half_v[15]}}, half_v}
            : f3 == 3'b100 ? {24'h0, byte_v}
            : f3 == 3'b101 ? {16'h0, half_v} : mem_rsp_data;
    sel_data = src_sel == 2'b00 ? ld_data : src_sel == 2'b01 ? src_alu : src_pc + 32'd4;
    go = state_d == WRITE;
    ok = go && op_ok && src_instr[11:7] != 5'd0 && src_sel != 2'b11 && !expire && (!src_load || f3_ok);
    rf_we_d = ok;
    rf_waddr_d = ok ? src_instr[11:7] : 5'd0;
    rf_wdata_d = ok ? sel_data : 32'h0;
    retire_d = go;
    load_timeout_d = load_timeout_q || expire;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      instr_q <= '0;
      alu_q <= '0;
      pc_q <= '0;
      wb_sel_q <= '0;
      addr_lo_q <= '0;
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      retire_q <= 1'b0;
      load_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      instr_q <= instr_d;
      alu_q <= alu_d;
      pc_q <= pc_d;
      wb_sel_q <= wb_sel_d;
      addr_lo_q <= addr_lo_d;
      rf_we_q <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      retire_q <= retire_d;
      load_timeout_q <= load_timeout_d;
    end
  end
  assign rf_we = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign retire = retire_q;
  assign load_timeout = load_timeout_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed tests for wb_stage
module tb_wb_stage;
  logic clk = 0, rst = 1, in_valid = 0, mem_rsp_valid = 0;
  logic in_ready, rf_we, retire, load_timeout;
  logic [31:0] in_instr = 0, in_alu = 0, in_pc = 0, mem_rsp_data = 0, rf_wdata;
  logic [1:0] in_wb_sel = 0, in_addr_lo = 0;
  logic [4:0] rf_waddr;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  wb_stage #(.LD_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_wb_sel(in_wb_sel), .in_alu(in_alu), .in_pc(in_pc), .in_addr_lo(in_addr_lo),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire(retire), .load_timeout(load_timeout)
  );
  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
    return {17'h0, f3, rd, op};
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [31:0] instr, input logic [1:0] sel, input logic [31:0] alu,
                      input logic [31:0] pc, input logic [1:0] addr);
    in_valid = 1; in_instr = instr; in_wb_sel = sel; in_alu = alu; in_pc = pc; in_addr_lo = addr;
  endtask
  task automatic test_reset;
    rst = 1;
    step; step;
    n_checks++;
    if ({in_ready, rf_we, rf_waddr, rf_wdata, retire, load_timeout} !== 41'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b we=%b wa=%0d wd=%h ret=%b to=%b exp all 0",
               in_ready, rf_we, rf_waddr, rf_wdata, retire, load_timeout);
    end
    rst = 0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready); end
  endtask
  task automatic test_alu;
    beat(mk(7'b0010011, 5, 0), 2'b01, 32'h00001234, 32'h100, 0);
    step;
    in_valid = 0;
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b1, 5'd5, 32'h00001234, 1'b1}) begin
      n_fail++;
      $display("FAIL addi_write got we=%b wa=%0d wd=%h ret=%b exp 1 5 00001234 1", rf_we, rf_waddr, rf_wdata, retire);
    end
    step;
    n_checks++;
    if ({rf_we, retire, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL addi_idle got we=%b ret=%b rdy=%b exp 0 0 1", rf_we, retire, in_ready);
    end
  endtask
  task automatic test_back_to_back;
    beat(mk(7'b1101111, 1, 0), 2'b10, 32'h0, 32'hFFFFFFFC, 0);
    step;
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, retire, in_ready} !== {1'b1, 5'd1, 32'h0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL jal_wrap got we=%b wa=%0d wd=%h ret=%b rdy=%b exp 1 1 00000000 1 1",
               rf_we, rf_waddr, rf_wdata, retire, in_ready);
    end
    beat(mk(7'b0010011, 5, 0), 2'b01, 32'h00000055, 32'h0, 0);
    step;
    in_valid = 0;
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b1, 5'd5, 32'h00000055, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_second got we=%b wa=%0d wd=%h ret=%b exp 1 5 00000055 1", rf_we, rf_waddr, rf_wdata, retire);
    end
    step;
    n_checks++;
    if ({rf_we, retire} !== 2'b00) begin n_fail++; $display("FAIL b2b_end got we=%b ret=%b exp 0 0", rf_we, retire); end
  endtask
  task automatic test_load;
    int busy = 0;
    beat(mk(7'b0000011, 7, 3'b000), 2'b00, 32'h0, 32'h0, 2'd3);
    step;
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      if (in_ready === 1'b0 && rf_we === 1'b0) busy++;
      if (i == 2) begin mem_rsp_valid = 1; mem_rsp_data = 32'h80FF0000; end
      step;
    end
    mem_rsp_valid = 0;
    n_checks++;
    if (busy !== 3) begin n_fail++; $display("FAIL lb_stall got %0d busy cycles exp 3", busy); end
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, retire, in_ready} !== {1'b1, 5'd7, 32'hFFFFFF80, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL lb_data got we=%b wa=%0d wd=%h ret=%b rdy=%b exp 1 7 ffffff80 1 1",
               rf_we, rf_waddr, rf_wdata, retire, in_ready);
    end
    beat(mk(7'b0000011, 8, 3'b101), 2'b00, 32'h0, 32'h0, 2'd2);
    step;
    in_valid = 0; mem_rsp_valid = 1;
    step;
    mem_rsp_valid = 0;
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 32'h000080FF}) begin
      n_fail++;
      $display("FAIL lhu_data got we=%b wa=%0d wd=%h exp 1 8 000080ff", rf_we, rf_waddr, rf_wdata);
    end
    beat(mk(7'b0000011, 9, 3'b011), 2'b00, 32'h0, 32'h0, 2'd0);
    step;
    in_valid = 0; mem_rsp_valid = 1;
    step;
    mem_rsp_valid = 0;
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b0, 5'd0, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL ld_bad_f3 got we=%b wa=%0d wd=%h ret=%b exp 0 0 0 1", rf_we, rf_waddr, rf_wdata, retire);
    end
  endtask
  task automatic test_nowrite;
    logic [31:0] ins [4];
    logic [1:0] sel [4];
    ins[0] = mk(7'b0100011, 5, 3'b010); sel[0] = 2'b01;
    ins[1] = mk(7'b1100011, 3, 3'b000); sel[1] = 2'b01;
    ins[2] = mk(7'b0010011, 0, 3'b000); sel[2] = 2'b01;
    ins[3] = mk(7'b0010011, 6, 3'b000); sel[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      beat(ins[i], sel[i], 32'hDEAD, 32'h40, 0);
      step;
      n_checks++;
      if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b0, 5'd0, 32'h0, 1'b1}) begin
        n_fail++;
        $display("FAIL nowrite_%0d got we=%b wa=%0d wd=%h ret=%b exp 0 0 0 1", i, rf_we, rf_waddr, rf_wdata, retire);
      end
    end
    in_valid = 0;
    step;
  endtask
  task automatic test_timeout;
    int n = 0;
    beat(mk(7'b0000011, 9, 3'b010), 2'b00, 32'h0, 32'h0, 0);
    step;
    in_valid = 0;
    do begin step; n++; end while (retire !== 1'b1 && n < 40);
    n_checks++;
    if (n !== 16) begin n_fail++; $display("FAIL timeout_cycles got %0d exp 16", n); end
    n_checks++;
    if ({load_timeout, rf_we, rf_wdata, retire} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_flags got to=%b we=%b wd=%h ret=%b exp 1 0 0 1", load_timeout, rf_we, rf_wdata, retire);
    end
    step;
    mem_rsp_valid = 1; mem_rsp_data = 32'h12345678;
    n_checks++;
    if ({in_ready, retire} !== 2'b10) begin n_fail++; $display("FAIL timeout_idle got rdy=%b ret=%b exp 1 0", in_ready, retire); end
    step;
    mem_rsp_valid = 0;
    n_checks++;
    if ({rf_we, retire, load_timeout} !== 3'b001) begin
      n_fail++;
      $display("FAIL late_rsp got we=%b ret=%b to=%b exp 0 0 1", rf_we, retire, load_timeout);
    end
  endtask
  task automatic test_reset_mid;
    beat(mk(7'b0000011, 10, 3'b010), 2'b00, 32'h0, 32'h0, 0);
    step;
    in_valid = 0;
    step;
    rst = 1;
    step;
    rst = 0;
    #1;
    n_checks++;
    if ({in_ready, rf_we, rf_waddr, rf_wdata, retire, load_timeout} !== {1'b1, 40'h0}) begin
      n_fail++;
      $display("FAIL rst_mid got rdy=%b we=%b wa=%0d wd=%h ret=%b to=%b exp 1 0 0 0 0 0",
               in_ready, rf_we, rf_waddr, rf_wdata, retire, load_timeout);
    end
    mem_rsp_valid = 1;
    step;
    mem_rsp_valid = 0;
    n_checks++;
    if ({rf_we, retire} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_rsp got we=%b ret=%b exp 0 0", rf_we, retire); end
  endtask
  task automatic test_limit_race;
    beat(mk(7'b0000011, 11, 3'b010), 2'b00, 32'h0, 32'h0, 0);
    step;
    in_valid = 0;
    for (int i = 0; i < 15; i++) step;
    mem_rsp_valid = 1; mem_rsp_data = 32'hCAFEF00D;
    step;
    mem_rsp_valid = 0;
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, retire, load_timeout} !== {1'b1, 5'd11, 32'hCAFEF00D, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL limit_race got we=%b wa=%0d wd=%h ret=%b to=%b exp 1 11 cafef00d 1 0",
               rf_we, rf_waddr, rf_wdata, retire, load_timeout);
    end
  endtask
  initial begin
    test_reset;
    test_alu;
    test_back_to_back;
    test_load;
    test_nowrite;
    test_timeout;
    test_reset_mid;
    test_limit_race;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
